// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

   // Controller states; encoding is fixed so state decodes stay trivial.
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

   // Digit-counter width: enough bits to count N steps, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      if (n <= 1) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// adder_digit: DIGIT-bit ripple chain of full-adder cells.
// c_msb is the carry into the top bit of the digit, used for signed overflow.
module adder_digit #(
   parameter int unsigned DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [DIGIT:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      // One full-adder cell per bit.
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout  = carry[DIGIT];
   assign c_msb = carry[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial A + B + CIN with valid/ready on both sides.
// Optional macro SERIAL_ADDER_OVF_EN adds the ovf_o port and its register.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf_o
`endif
);

   localparam int unsigned DigitSafe = (DIGIT == 0) ? 1 : DIGIT;
   localparam int unsigned NSteps    = WIDTH / DigitSafe;
   localparam int unsigned CntW      = cnt_width(NSteps);
   localparam logic [CntW-1:0] LastCnt = CntW'(NSteps - 1);

   if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DigitSafe) != 0)) begin : g_param_err
      $error("serial_adder: WIDTH must be >= 1 and DIGIT must be >= 1 and divide WIDTH");
   end

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              c_q, c_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic              ovf_q, ovf_d;
`endif

   logic [DIGIT-1:0]  dig_sum;
   logic              dig_cout;
   logic              dig_c_msb;
   logic [WIDTH-1:0]  res_shift;

   adder_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .a     (a_q[DIGIT-1:0]),
      .b     (b_q[DIGIT-1:0]),
      .cin   (c_q),
      .sum   (dig_sum),
      .cout  (dig_cout),
      .c_msb (dig_c_msb)
   );

`ifndef SERIAL_ADDER_OVF_EN
   logic unused_c_msb;
   assign unused_c_msb = dig_c_msb;
`endif

   // New digit enters the partial-result register at the MSB end; the oldest bits fall off.
   assign res_shift = WIDTH'({dig_sum, res_q} >> DIGIT);

   // Next-state and datapath update; outputs registers only load on the final step.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               a_d     = a_i;
               b_d     = b_i;
               c_d     = cin_i;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            c_d   = dig_cout;
            res_d = res_shift;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               sum_d   = res_shift;
               cout_d  = dig_cout;
`ifdef SERIAL_ADDER_OVF_EN
               // On the last step the digit's top bit is bit WIDTH-1 of the word.
               ovf_d   = dig_c_msb ^ dig_cout;
`endif
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready_i) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously so no partial result survives reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready_o  = (state_q == StIdle);
   assign out_valid_o = (state_q == StDone);
   assign sum_o       = sum_q;
   assign cout_o      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (W1/D1, W8/D1, W16/D4).
// Driver pushes expected results; a negedge monitor pops and compares on each handshake.
module tb_serial_adder;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  in_valid = '0;
   logic [2:0]  out_ready = '0;
   logic [2:0]  cin_v = '0;
   logic [15:0] a_v [3];
   logic [15:0] b_v [3];
   logic [2:0]  in_ready_w;
   logic [2:0]  out_valid_w;
   logic [2:0]  cout_w;
   logic [0:0]  sum1;
   logic [7:0]  sum8;
   logic [15:0] sum16;
`ifdef SERIAL_ADDER_OVF_EN
   logic [2:0]  ovf_w;
`endif

   int n_checks = 0;
   int n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   logic [2:0] fa_tt [8];

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
      .clk_i (clk), .rst_ni (rst_n),
      .in_valid_i (in_valid[0]), .in_ready_o (in_ready_w[0]),
      .a_i (a_v[0][0:0]), .b_i (b_v[0][0:0]), .cin_i (cin_v[0]),
      .out_valid_o (out_valid_w[0]), .out_ready_i (out_ready[0]),
      .sum_o (sum1), .cout_o (cout_w[0])
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf_o (ovf_w[0])
`endif
   );

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8 (
      .clk_i (clk), .rst_ni (rst_n),
      .in_valid_i (in_valid[1]), .in_ready_o (in_ready_w[1]),
      .a_i (a_v[1][7:0]), .b_i (b_v[1][7:0]), .cin_i (cin_v[1]),
      .out_valid_o (out_valid_w[1]), .out_ready_i (out_ready[1]),
      .sum_o (sum8), .cout_o (cout_w[1])
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf_o (ovf_w[1])
`endif
   );

   serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16 (
      .clk_i (clk), .rst_ni (rst_n),
      .in_valid_i (in_valid[2]), .in_ready_o (in_ready_w[2]),
      .a_i (a_v[2]), .b_i (b_v[2]), .cin_i (cin_v[2]),
      .out_valid_o (out_valid_w[2]), .out_ready_i (out_ready[2]),
      .sum_o (sum16), .cout_o (cout_w[2])
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf_o (ovf_w[2])
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] get_sum(input int d);
      case (d)
         0: return {15'b0, sum1};
         1: return {8'b0, sum8};
         default: return sum16;
      endcase
   endfunction

   function automatic int n_steps(input int d);
      case (d)
         0: return 1;
         1: return 8;
         default: return 4;
      endcase
   endfunction

   task automatic push_exp(input int d, input exp_t e);
      case (d)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Monitor: compare against the scoreboard whenever a result is handed over.
   always @(negedge clk) begin
      exp_t e;
      logic have;
      for (int d = 0; d < 3; d++) begin
         if (rst_n && out_valid_w[d] && out_ready[d]) begin
            have = 1'b0;
            e = '0;
            case (d)
               0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
               1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
               default: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
            endcase
            chk($sformatf("dut%0d result expected", d), {31'b0, have}, 32'd1);
            if (have) begin
               chk($sformatf("dut%0d sum", d), {16'b0, get_sum(d)}, {16'b0, e.sum});
               chk($sformatf("dut%0d cout", d), {31'b0, cout_w[d]}, {31'b0, e.cout});
`ifdef SERIAL_ADDER_OVF_EN
               chk($sformatf("dut%0d ovf", d), {31'b0, ovf_w[d]}, {31'b0, e.ovf});
`endif
            end
         end
      end
   end

   // One operation: push expectation, accept, measure latency, optionally stall, hand over.
   task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [15:0] es, input logic ec,
                         input logic eo, input int hold);
      int k;
      exp_t e;
      e.sum = es;
      e.cout = ec;
      e.ovf = eo;
      push_exp(d, e);
      k = 0;
      while (!in_ready_w[d] && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk($sformatf("dut%0d in_ready before accept", d), {31'b0, in_ready_w[d]}, 32'd1);
      a_v[d] = a;
      b_v[d] = b;
      cin_v[d] = c;
      in_valid[d] = 1'b1;
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      a_v[d] = ~a;
      b_v[d] = ~b;
      k = 0;
      while (!out_valid_w[d] && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk($sformatf("dut%0d latency", d), k, n_steps(d));
      for (int i = 0; i < hold; i++) begin
         in_valid[d] = i[0] ? 1'b0 : 1'b1;
         @(posedge clk); #1;
         chk($sformatf("dut%0d frozen sum", d), {16'b0, get_sum(d)}, {16'b0, es});
         chk($sformatf("dut%0d frozen cout", d), {31'b0, cout_w[d]}, {31'b0, ec});
         chk($sformatf("dut%0d in_ready in DONE", d), {31'b0, in_ready_w[d]}, 32'd0);
         chk($sformatf("dut%0d out_valid held", d), {31'b0, out_valid_w[d]}, 32'd1);
      end
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      out_ready[d] = 1'b0;
      chk($sformatf("dut%0d idle after handshake", d), {31'b0, in_ready_w[d]}, 32'd1);
      chk($sformatf("dut%0d out_valid drop", d), {31'b0, out_valid_w[d]}, 32'd0);
   endtask

   task automatic chk_reset_state(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s dut%0d in_ready", tag, d), {31'b0, in_ready_w[d]}, 32'd1);
         chk($sformatf("%s dut%0d out_valid", tag, d), {31'b0, out_valid_w[d]}, 32'd0);
         chk($sformatf("%s dut%0d sum", tag, d), {16'b0, get_sum(d)}, 32'd0);
         chk($sformatf("%s dut%0d cout", tag, d), {31'b0, cout_w[d]}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
         chk($sformatf("%s dut%0d ovf", tag, d), {31'b0, ovf_w[d]}, 32'd0);
`endif
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ra, rb;
      logic rc;
      logic [16:0] full;
      logic [2:0] iv;
      for (int d = 0; d < 3; d++) begin
         a_v[d] = '0;
         b_v[d] = '0;
      end
      // {ovf, cout, sum} for {a, b, cin} = 0..7
      fa_tt[0] = 3'b000; fa_tt[1] = 3'b101; fa_tt[2] = 3'b001; fa_tt[3] = 3'b010;
      fa_tt[4] = 3'b001; fa_tt[5] = 3'b010; fa_tt[6] = 3'b110; fa_tt[7] = 3'b011;

      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Full-adder truth table on the 1-bit instance.
      for (int i = 0; i < 8; i++) begin
         iv = 3'(i);
         run_op(0, {15'b0, iv[2]}, {15'b0, iv[1]}, iv[0], {15'b0, fa_tt[i][0]},
                fa_tt[i][1], fa_tt[i][2], 0);
      end

      // 8-bit directed vectors.
      run_op(1, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
      run_op(1, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1, 0);
      run_op(1, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
      // Backpressure: 5 stalled cycles with IN_VALID pulsing, then back-to-back accept.
      run_op(1, 16'h005A, 16'h0033, 1'b0, 16'h008D, 1'b0, 1'b1, 5);
      run_op(1, 16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 1'b0, 0);

      // 16-bit, 4-bit digits: all-ones plus carry-in.
      run_op(2, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);

      // Reset after 3 of 8 RUN steps on the 8-bit instance.
      a_v[1] = 16'h00AA;
      b_v[1] = 16'h0055;
      cin_v[1] = 1'b1;
      in_valid[1] = 1'b1;
      @(posedge clk); #1;
      in_valid[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("mid-run out_valid", {31'b0, out_valid_w[1]}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk_reset_state("mid-run reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(1, 16'h0012, 16'h0034, 1'b1, 16'h0047, 1'b0, 1'b0, 0);

      // Random 16-bit operands against a behavioural reference.
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         full = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
         run_op(2, ra, rb, rc, full[15:0], full[16],
                (ra[15] == rb[15]) && (full[15] != ra[15]), 0);
      end

      @(posedge clk); #1;
      chk("scoreboard dut0 drained", q0.size(), 0);
      chk("scoreboard dut1 drained", q1.size(), 0);
      chk("scoreboard dut2 drained", q2.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised digit-serial adder with valid/ready handshakes on both sides. It computes A + B + CIN over WIDTH bits, processing DIGIT bits per clock, and presents SUM and COUT until the consumer accepts them. It is the multi-bit, sequential successor to the team's single-bit full adder, and its datapath slice reuses that full-adder cell. It sits between an operand producer and a result consumer wherever area matters more than throughput.

## Interface
Parameters:
- WIDTH, default 8: operand and sum width in bits; must be at least 1.
- DIGIT, default 1: bits processed per cycle; must be at least 1 and divide WIDTH. Any other value is an elaboration error.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  producer presents an operand set.
- IN_READY  out  1  block accepts an operand set; high only in IDLE.
- A  in  WIDTH  operand A; sampled on the accept edge.
- B  in  WIDTH  operand B; sampled on the accept edge.
- CIN  in  1  carry-in; sampled on the accept edge.
- OUT_VALID  out  1  result is valid; high only in DONE.
- OUT_READY  in  1  consumer accepts the result.
- SUM  out  WIDTH  (A + B + CIN) mod 2^WIDTH.
- COUT  out  1  bit WIDTH of A + B + CIN.
- OVF  out  1  two's-complement overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- N = WIDTH/DIGIT digit steps per operation.
- States:
  - IDLE: IN_READY = 1. On IN_VALID, capture A, B and CIN, clear the digit counter, and go to RUN.
  - RUN: each edge adds the low DIGIT bits of the operand registers plus the carry register. The result digit is shifted into the sum register from the MSB end, the operands shift right by DIGIT, and the carry register is updated. After step N, go to DONE.
  - DONE: OUT_VALID = 1. On OUT_READY, go to IDLE.
- IN_VALID is ignored outside IDLE. OUT_READY is ignored outside DONE.
- SUM, COUT and OVF are registered. They are stable throughout DONE and hold their last values in IDLE and RUN.
- OVF = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, captured at the final step.
- Reset, including mid-RUN: all registers clear immediately and the state goes to IDLE. Reset values: IN_READY 1, OUT_VALID 0, SUM 0, COUT 0, OVF 0. No partial result is ever presented.

## Timing
- Accept edge at cycle 0. OUT_VALID rises after edge N, i.e. latency N cycles from accept to result.
- Minimum period is N+2 cycles: accept edge, N RUN edges, one DONE handshake edge, then IDLE.
- There is no combinational path from inputs to outputs. IN_READY and OUT_VALID decode directly from the state register.
- Backpressure: DONE is held indefinitely while OUT_READY = 0, with outputs frozen.
- WIDTH = DIGIT, so N = 1: still one RUN cycle, latency 1.

## Configuration
- SERIAL_ADDER_OVF_EN:
  - Defined: the OVF port and its register exist, computed as above.
  - Undefined: no OVF port and no extra logic. All other behaviour is identical.

## Structure
- Package serial_adder_pkg holds:
  - the state typedef (IDLE, RUN, DONE) with its fixed 2-bit encoding;
  - a width function for the digit counter, $clog2(N) with a minimum of 1.
- Sub-module adder_digit: DIGIT-bit ripple chain of full-adder cells.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_msb (the carry into the top bit), which is used for OVF.
- Top level: FSM, operand and sum shift registers, carry register, digit counter.

## Test plan
- WIDTH=1, DIGIT=1, all 8 combinations of A/B/CIN: SUM/COUT match the full-adder truth table, e.g. 1,1,1 gives SUM 1, COUT 1, latency 1.
- WIDTH=8, DIGIT=1, A=0xFF, B=0x01, CIN=0: SUM 0x00, COUT 1, OVF 0. OUT_VALID rises exactly 8 cycles after accept.
- WIDTH=8, macro defined, A=0x7F, B=0x01, CIN=0: SUM 0x80, COUT 0, OVF 1. Then A=0x80, B=0x80: SUM 0x00, COUT 1, OVF 1.
- Backpressure: hold OUT_READY low for 5 cycles in DONE while pulsing IN_VALID. SUM/COUT stay frozen and IN_READY stays 0. After the handshake, IDLE is reached and the next accept occurs one edge later.
- Reset mid-RUN: assert RST_N low after 3 of 8 steps. All outputs read zero, IN_READY reads 1. The next op A=0x12, B=0x34, CIN=1 gives SUM 0x47, COUT 0.
- WIDTH=16, DIGIT=4, A=0xFFFF, B=0xFFFF, CIN=1: SUM 0xFFFF, COUT 1, latency 4. Follow with 1000 random operands checked against a behavioural reference.
